// File: rtl/vga_scan_ctrl.sv
// rtl/vga_scan_ctrl.sv - VGA scan controller with frame-buffer read sequencing
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int IMG_X0   = 192,
  parameter int IMG_Y0   = 112,
  parameter int ADDR_W   = 16,
  parameter int PIX_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [PIX_W-1:0]  mem_data,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic [PIX_W-1:0]  rgb,
  output logic              frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] H_LAST   = 32'(H_TOT - 1);
  localparam logic [31:0] V_LAST   = 32'(V_TOT - 1);
  localparam logic [31:0] X_LO     = 32'(IMG_X0);
  localparam logic [31:0] X_HI     = 32'(IMG_X0 + IMG_W);
  localparam logic [31:0] Y_LO     = 32'(IMG_Y0);
  localparam logic [31:0] Y_HI     = 32'(IMG_Y0 + IMG_H);

  // The image window has to sit inside the visible area and fit the address space.
  if (IMG_X0 < 0 || IMG_Y0 < 0 || IMG_X0 + IMG_W > H_ACTIVE ||
      IMG_Y0 + IMG_H > V_ACTIVE) begin : g_window_check
    $error("vga_scan_ctrl: image window must lie inside the visible area");
  end

  if (ADDR_W > 32 || $clog2(IMG_W * IMG_H) > ADDR_W) begin : g_addr_check
    $error("vga_scan_ctrl: ADDR_W cannot address the whole image");
  end

  // run is low during reset and for the release edge, so the first cycle
  // after release is phase A of pixel (0,0)
  logic          run;
  logic          tick;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          rd_q;

  logic [31:0]   hx;
  logic [31:0]   vx;
  logic          in_img;
  logic          in_hsync;
  logic          in_vsync;
  logic          in_vis;
  logic          last_h;
  logic          last_v;

  // Decode of the current scan position and the phase-A read strobe
  always_comb begin
    hx       = 32'(h);
    vx       = 32'(v);
    in_img   = (hx >= X_LO) && (hx < X_HI) && (vx >= Y_LO) && (vx < Y_HI);
    in_hsync = (hx >= HS_START) && (hx < HS_END);
    in_vsync = (vx >= VS_START) && (vx < VS_END);
    in_vis   = (hx < 32'(H_ACTIVE)) && (vx < 32'(V_ACTIVE));
    last_h   = (hx == H_LAST);
    last_v   = (vx == V_LAST);
    mem_rd   = 1'b0;
    mem_addr = '0;
    if (run && !tick && enable && in_img) begin
      mem_rd   = 1'b1;
      mem_addr = ADDR_W'((vx - Y_LO) * 32'(IMG_W) + (hx - X_LO));
    end
    frame_start = run && !tick && (h == '0) && (v == '0);
  end

  // Pixel tick and scan counters; counters step at the end of phase B
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run  <= 1'b0;
      tick <= 1'b0;
      h    <= '0;
      v    <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        tick <= ~tick;
      end
      if (run && tick) begin
        if (last_h) begin
          h <= '0;
          if (last_v) begin
            v <= '0;
          end else begin
            v <= v + VW'(1);
          end
        end else begin
          h <= h + HW'(1);
        end
      end
    end
  end

  // Remember whether the current pixel issued a read so phase B knows to use mem_data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= 1'b0;
    end else if (!tick) begin
      rd_q <= mem_rd;
    end
  end

  // Output register: everything for pixel (h,v) is loaded together at the end of phase B
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
      rgb      <= '0;
    end else if (run && tick) begin
      hsync    <= ~in_hsync;
      vsync    <= ~in_vsync;
      video_on <= in_vis;
      rgb      <= rd_q ? mem_data : '0;
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb/tb_vga_scan_ctrl.sv - scoreboard bench for vga_scan_ctrl on a reduced screen
module tb_vga_scan_ctrl;

  localparam int H_ACTIVE = 40;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 6;
  localparam int H_BP     = 6;
  localparam int V_ACTIVE = 30;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;
  localparam int IMG_W    = 16;
  localparam int IMG_H    = 8;
  localparam int IMG_X0   = 10;
  localparam int IMG_Y0   = 12;
  localparam int ADDR_W   = 7;
  localparam int PIX_W    = 8;

  localparam int H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_PIX = H_TOT * V_TOT;
  localparam int FRAME_CLK = 2 * FRAME_PIX;
  localparam int TARGET    = 2 * ((IMG_Y0 + 3) * H_TOT + IMG_X0 + 5);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [PIX_W-1:0]  mem_data;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              hsync;
  logic              vsync;
  logic              video_on;
  logic [PIX_W-1:0]  rgb;
  logic              frame_start;

  always #10 clk = ~clk;

  vga_scan_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .IMG_X0(IMG_X0), .IMG_Y0(IMG_Y0),
    .ADDR_W(ADDR_W), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mem_data(mem_data),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .rgb(rgb), .frame_start(frame_start)
  );

  typedef struct {
    int                idx;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic              hs;
    logic              vs;
    logic              von;
    logic [PIX_W-1:0]  rgb;
    logic              fs;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state: cycle index since reset release and pixel records
  int   n = 0;
  bit   cur_rd, sh_rd, shown_ok;
  int   cur_addr, cur_h, cur_v, sh_addr, sh_h, sh_v;
  logic              bram_rd;
  logic [ADDR_W-1:0] bram_addr;
  bit   en_r;

  function automatic logic [PIX_W-1:0] bram_val(input int a);
    return PIX_W'((a * 37 + 11) & 255);
  endfunction

  task automatic model_cycle(input bit was_rst, input bit en, output exp_t e);
    int p, h, v;
    e.idx = was_rst ? -1 : n;
    e.rd = 1'b0; e.addr = '0; e.fs = 1'b0;
    e.hs = 1'b1; e.vs = 1'b1; e.von = 1'b0; e.rgb = '0;
    if (was_rst) begin
      n = 0;
      shown_ok = 0;
      return;
    end
    p = (n / 2) % FRAME_PIX;
    h = p % H_TOT;
    v = p / H_TOT;
    if (n % 2 == 0) begin
      if (n >= 2) begin
        shown_ok = 1; sh_rd = cur_rd; sh_addr = cur_addr; sh_h = cur_h; sh_v = cur_v;
      end
      cur_h = h; cur_v = v;
      cur_rd = en && h >= IMG_X0 && h < IMG_X0 + IMG_W && v >= IMG_Y0 && v < IMG_Y0 + IMG_H;
      cur_addr = cur_rd ? (v - IMG_Y0) * IMG_W + (h - IMG_X0) : 0;
      e.rd = cur_rd;
      e.addr = ADDR_W'(cur_addr);
      e.fs = (p == 0);
    end
    if (shown_ok) begin
      e.hs  = !(sh_h >= H_ACTIVE + H_FP && sh_h < H_ACTIVE + H_FP + H_SYNC);
      e.vs  = !(sh_v >= V_ACTIVE + V_FP && sh_v < V_ACTIVE + V_FP + V_SYNC);
      e.von = (sh_h < H_ACTIVE) && (sh_v < V_ACTIVE);
      e.rgb = sh_rd ? bram_val(sh_addr) : '0;
    end
    n++;
  endtask

  // one clock: rst_next is sampled at the edge that starts the cycle, enable applies within it
  task automatic step(input bit rst_next, input bit en);
    exp_t e;
    @(negedge clk);
    bram_rd = mem_rd;
    bram_addr = mem_addr;
    rst_n = rst_next;
    @(posedge clk);
    #1;
    enable = en;
    if (bram_rd === 1'b1) mem_data = bram_val(int'(bram_addr));
    else mem_data = PIX_W'($urandom);
    model_cycle(!rst_next, en, e);
    sb.push_back(e);
  endtask

  // monitor: pops one expectation per cycle and compares at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if ({mem_rd, mem_addr, hsync, vsync, video_on, rgb, frame_start} !==
            {e.rd, e.addr, e.hs, e.vs, e.von, e.rgb, e.fs}) begin
          miscompares++;
          $display("FAIL scan_out n=%0d got rd=%b addr=%0d hs=%b vs=%b von=%b rgb=%0h fs=%b want rd=%b addr=%0d hs=%b vs=%b von=%b rgb=%0h fs=%b",
                   e.idx, mem_rd, mem_addr, hsync, vsync, video_on, rgb, frame_start,
                   e.rd, e.addr, e.hs, e.vs, e.von, e.rgb, e.fs);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    mem_data = '0;
    bram_rd = 1'b0;
    bram_addr = '0;
    repeat (5) step(0, 1'($urandom_range(0, 1)));
    repeat (FRAME_CLK + 200) step(1, 1);
    repeat (FRAME_CLK) step(1, 0);
    en_r = 1;
    repeat (FRAME_CLK) begin
      if ($urandom_range(0, 7) == 0) en_r = !en_r;
      step(1, en_r);
    end
    for (int i = 0; i < FRAME_CLK && (n % FRAME_CLK) != TARGET; i++) step(1, 1);
    step(1, 1);
    repeat (3) step(0, 1'($urandom_range(0, 1)));
    repeat (FRAME_CLK + 300) begin
      if ($urandom_range(0, 5) == 0) en_r = !en_r;
      step(1, en_r);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
